// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HI
   } rx_state_t;

   localparam int BAUD_DIV_DEFAULT = 163;
   localparam int DATA_BITS        = 8;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and acknowledge in, byte/status out.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 RX;
   logic                 clr_rdy;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rdy;
   logic                 frm_err;

   modport master (
      output RX,
      output clr_rdy,
      input  rx_data,
      input  rdy,
      input  frm_err
   );

   modport slave (
      input  RX,
      input  clr_rdy,
      output rx_data,
      output rdy,
      output frm_err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_rx_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a cycle-counted baud timer,
// false-start rejection and framing-error reporting.
module uart_rx
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_rx_if.slave  bus
);

   localparam int HALF = BAUD_DIV / 2;
   localparam int CW   = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] BAUD_M1 = CW'(BAUD_DIV - 1);

   logic                 w_rx_s;
   rx_state_t            r_state;
   logic [CW-1:0]        r_baud;
   logic [3:0]           r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_rdy;
   logic                 r_frm_err;

   uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (bus.RX),
      .o_q   (w_rx_s)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_baud    <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_data    <= '0;
         r_rdy     <= 1'b0;
         r_frm_err <= 1'b0;
      end else begin
         // Acknowledge first so a same-cycle set in STOP overrides it.
         if (bus.clr_rdy) r_rdy <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_rx_s) begin
                  r_baud  <= '0;
                  r_rdy   <= 1'b0;
                  r_state <= START;
               end
            end
            START: begin
               if (r_baud == HALF_M1) begin
                  if (w_rx_s) begin
                     r_state <= IDLE;
                  end else begin
                     r_baud  <= '0;
                     r_bit   <= '0;
                     r_state <= DATA;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            DATA: begin
               if (r_baud == BAUD_M1) begin
                  r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit   <= r_bit + 4'd1;
                  r_baud  <= '0;
                  if (r_bit == 4'(DATA_BITS - 1)) r_state <= STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            STOP: begin
               if (r_baud == BAUD_M1) begin
                  if (w_rx_s) begin
                     r_data    <= r_shift;
                     r_rdy     <= 1'b1;
                     r_frm_err <= 1'b0;
                     r_state   <= IDLE;
                  end else begin
                     r_frm_err <= 1'b1;
                     r_state   <= WAIT_HI;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end
            WAIT_HI: begin
               // A held-low line must return high before a new start counts.
               if (w_rx_s) r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.rx_data = r_data;
   assign bus.rdy     = r_rdy;
   assign bus.frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated bit by bit, the expected
// outcome of each frame is queued, and a monitor checks every rdy/frm_err rise.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int B    = 163;
   localparam int HALF = B / 2;
   localparam int LAT  = HALF + 9 * B + 3;

   typedef struct {
      bit         good;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   exp_t       sbq[$];
   logic [7:0] last_good = 8'h00;
   logic       prev_rdy = 1'b0;
   logic       prev_fe  = 1'b0;

   uart_rx_if bus();

   uart_rx #(.BAUD_DIV(B)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: start bit, 8 data bits LSB first, stop bit (good: 1 for B
   // cycles; bad: 0 for 2*B cycles). Outcome lands LAT cycles after the start edge.
   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int gap);
      exp_t e;
      e.good = stop_ok;
      e.data = d;
      e.cyc  = cyc + LAT;
      sbq.push_back(e);
      bus.RX = 1'b0;
      repeat (B) tick();
      for (int i = 0; i < 8; i++) begin
         bus.RX = d[i];
         repeat (B) tick();
      end
      if (stop_ok) begin
         bus.RX = 1'b1;
         repeat (B) tick();
      end else begin
         bus.RX = 1'b0;
         repeat (2 * B) tick();
         bus.RX = 1'b1;
      end
      repeat (gap) tick();
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.rdy && !prev_rdy) begin
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_rdy: rx_data 0x%0h at cycle %0d, expected no frame", bus.rx_data, cyc);
               end else begin
                  e = sbq.pop_front();
                  chk("frame_kind_rdy", 1, int'(e.good));
                  chk("rx_data", int'(bus.rx_data), int'(e.data));
                  chk("frm_err_on_good", int'(bus.frm_err), 0);
                  chk("rdy_cycle", cyc, e.cyc);
                  if (e.good) last_good = e.data;
               end
            end else if (bus.frm_err && !prev_fe) begin
               if (sbq.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frm_err: at cycle %0d, expected no frame", cyc);
               end else begin
                  e = sbq.pop_front();
                  chk("frame_kind_err", 0, int'(e.good));
                  chk("rdy_on_err", int'(bus.rdy), 0);
                  chk("rx_data_held_on_err", int'(bus.rx_data), int'(last_good));
                  chk("frm_err_cycle", cyc, e.cyc);
               end
            end
         end
         prev_rdy = bus.rdy;
         prev_fe  = bus.frm_err;
      end
   end

   initial begin
      int  n;
      bit  prev_bad;
      bit  bad;
      logic [7:0] d;

      rst_n       = 1'b0;
      bus.RX      = 1'b1;
      bus.clr_rdy = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("reset_rdy", int'(bus.rdy), 0);
      chk("reset_frm_err", int'(bus.frm_err), 0);
      chk("reset_rx_data", int'(bus.rx_data), 0);
      tick();

      // Plain frame
      send_frame(8'hA5, 1'b1, 20);

      // Glitch shorter than half a bit, then a frame right after return to IDLE
      n = cyc;
      bus.RX = 1'b0;
      repeat (20) tick();
      bus.RX = 1'b1;
      while (cyc < n + 3 + HALF + 1) tick();
      send_frame(8'h5A, 1'b1, 20);

      // Framing error; frm_err must survive clr_rdy
      send_frame(8'h3C, 1'b0, 20);
      bus.clr_rdy = 1'b1;
      tick();
      bus.clr_rdy = 1'b0;
      tick();
      @(negedge clk);
      chk("frm_err_after_clr", int'(bus.frm_err), 1);
      tick();
      send_frame(8'h81, 1'b1, 20);

      // clr_rdy in the same cycle rdy sets: set wins
      n = cyc;
      fork
         send_frame(8'hC3, 1'b1, 20);
         begin
            while (cyc < n + LAT - 1) tick();
            bus.clr_rdy = 1'b1;
            tick();
            bus.clr_rdy = 1'b0;
            @(negedge clk);
            chk("collide_rdy", int'(bus.rdy), 1);
         end
      join

      // clr_rdy one cycle after rdy sets: cleared, data held
      n = cyc;
      fork
         send_frame(8'h96, 1'b1, 20);
         begin
            while (cyc < n + LAT) tick();
            bus.clr_rdy = 1'b1;
            tick();
            bus.clr_rdy = 1'b0;
            @(negedge clk);
            chk("late_clr_rdy", int'(bus.rdy), 0);
            chk("late_clr_data", int'(bus.rx_data), 8'h96);
         end
      join

      // Reset during data bit 4, with frm_err set and data nonzero beforehand
      send_frame(8'h11, 1'b0, 20);
      d = 8'h6B;
      bus.RX = 1'b0;
      repeat (B) tick();
      for (int i = 0; i < 4; i++) begin
         bus.RX = d[i];
         repeat (B) tick();
      end
      bus.RX = d[4];
      repeat (HALF) tick();
      rst_n = 1'b0;
      tick();
      rst_n     = 1'b1;
      bus.RX    = 1'b1;
      last_good = 8'h00;
      @(negedge clk);
      chk("midreset_rdy", int'(bus.rdy), 0);
      chk("midreset_frm_err", int'(bus.frm_err), 0);
      chk("midreset_rx_data", int'(bus.rx_data), 0);
      repeat (2 * B) tick();
      send_frame(8'h3C, 1'b1, 20);

      // Back-to-back, no idle between frames
      send_frame(8'h00, 1'b1, 0);
      send_frame(8'hFF, 1'b1, 20);

      // Randomized frames; a bad frame is always followed by some idle line
      prev_bad = 1'b0;
      for (int k = 0; k < 12; k++) begin
         d   = 8'($urandom);
         bad = !prev_bad && ($urandom_range(0, 3) == 0);
         send_frame(d, !bad, bad ? int'($urandom_range(8, B)) : int'($urandom_range(0, B)));
         prev_bad = bad;
      end

      // Bounded drain of the scoreboard
      for (int w = 0; w < 4 * B && sbq.size() != 0; w++) tick();
      chk("scoreboard_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
